// File: rtl/irq_gen_pkg.sv
// Shared types and helpers for the multi-channel interrupt generator.
package irq_gen_pkg;

    typedef enum logic [1:0] {
        IRQ_PULSE  = 2'b00,
        IRQ_LEVEL  = 2'b01,
        IRQ_TOGGLE = 2'b10,
        IRQ_RSVD   = 2'b11
    } irq_mode_e;

    // Width of the pulse-width counter: must hold PULSE_W itself.
    function automatic int unsigned pw_width(input int unsigned pulse_w);
        return $clog2(pulse_w + 1);
    endfunction

endpackage

// File: rtl/irq_gen_chan.sv
// One interrupt channel: period counter, output mode logic and sticky overrun flag.
module irq_gen_chan
    import irq_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = 27,
    parameter int unsigned PULSE_W = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic             ack,
    input  logic             ovr_clr,
    output logic             irq,
    output logic             evt,
    output logic             ovr
);

    localparam int unsigned PW_W = pw_width(PULSE_W);

    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_last;
    logic [PW_W-1:0]  wcnt, wcnt_nxt;
    irq_mode_e        mode_cur, mode_q;
    logic             active, fire, mode_chg, ovr_set;
    logic             irq_nxt, ovr_nxt;

    always_comb begin
        mode_cur = irq_mode_e'(mode);
        active   = en && (period != '0);
        cnt_last = period - CNT_W'(1);
        // >= rather than == so a period shrunk below cnt fires on the next tick
        fire     = active && tick && (cnt >= cnt_last);
        mode_chg = (mode_cur != mode_q);
        cnt_nxt  = cnt;
        wcnt_nxt = wcnt;
        irq_nxt  = irq;
        ovr_nxt  = ovr;
        ovr_set  = 1'b0;
        if (!active) begin
            cnt_nxt  = '0;
            wcnt_nxt = '0;
            irq_nxt  = 1'b0;
        end else begin
            if (tick) cnt_nxt = fire ? '0 : cnt + CNT_W'(1);
            if (mode_chg) begin
                wcnt_nxt = '0;
                irq_nxt  = 1'b0;
            end else begin
                case (mode_cur)
                    IRQ_PULSE: begin
                        if (fire) begin
                            ovr_set  = irq;
                            irq_nxt  = 1'b1;
                            wcnt_nxt = PW_W'(PULSE_W);
                        end else if (wcnt > PW_W'(1)) begin
                            wcnt_nxt = wcnt - PW_W'(1);
                        end else begin
                            wcnt_nxt = '0;
                            irq_nxt  = 1'b0;
                        end
                    end
                    IRQ_LEVEL: begin
                        if (fire) begin
                            ovr_set = irq;
                            irq_nxt = 1'b1;
                        end else if (ack) begin
                            irq_nxt = 1'b0;
                        end
                    end
                    IRQ_TOGGLE: begin
                        wcnt_nxt = '0;
                        if (fire) irq_nxt = ~irq;
                    end
                    default: begin
                        wcnt_nxt = '0;
                        irq_nxt  = 1'b0;
                    end
                endcase
            end
            if (ovr_set)      ovr_nxt = 1'b1;
            else if (ovr_clr) ovr_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            wcnt   <= '0;
            irq    <= 1'b0;
            evt    <= 1'b0;
            ovr    <= 1'b0;
            mode_q <= IRQ_PULSE;
        end else begin
            cnt    <= cnt_nxt;
            wcnt   <= wcnt_nxt;
            irq    <= irq_nxt;
            evt    <= fire;
            ovr    <= ovr_nxt;
            mode_q <= mode_cur;
        end
    end

endmodule

// File: rtl/irq_gen_multi.sv
// N_CH independent interrupt/event generators sharing one tick prescaler.
module irq_gen_multi
    import irq_gen_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = 27,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned PULSE_W  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       en_i,
    input  logic [2*N_CH-1:0]     mode_i,
    input  logic [CNT_W*N_CH-1:0] period_i,
    input  logic [N_CH-1:0]       ack_i,
    input  logic [N_CH-1:0]       ovr_clr_i,
    output logic [N_CH-1:0]       irq_o,
    output logic [N_CH-1:0]       evt_o,
    output logic [N_CH-1:0]       ovr_o
);

    logic tick;

    if (PRESCALE > 1) begin : g_ps
        localparam int unsigned PS_W = $clog2(PRESCALE);
        logic [PS_W-1:0] ps;

        assign tick = (ps == PS_W'(PRESCALE - 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)    ps <= '0;
            else if (tick) ps <= '0;
            else           ps <= ps + PS_W'(1);
        end
    end else begin : g_no_ps
        assign tick = 1'b1;
    end

    for (genvar n = 0; n < N_CH; n++) begin : g_ch
        irq_gen_chan #(
            .CNT_W   (CNT_W),
            .PULSE_W (PULSE_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .en      (en_i[n]),
            .mode    (mode_i[2*n +: 2]),
            .period  (period_i[CNT_W*n +: CNT_W]),
            .ack     (ack_i[n]),
            .ovr_clr (ovr_clr_i[n]),
            .irq     (irq_o[n]),
            .evt     (evt_o[n]),
            .ovr     (ovr_o[n])
        );
    end

endmodule
